// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl_if
// Purpose  : Rx/Tx FIFO handshake bundle between uart_cmd_ctrl and the UART core.
// Revision : 1.0
// ============================================================================
interface uart_cmd_ctrl_if #(
    parameter int DBITS = 8
);
    logic             rx_empty;
    logic [DBITS-1:0] read_data;
    logic             read_uart;
    logic             tx_full;
    logic             write_uart;
    logic [DBITS-1:0] write_data;

    modport master (
        input  rx_empty, read_data, tx_full,
        output read_uart, write_uart, write_data
    );

    modport slave (
        output rx_empty, read_data, tx_full,
        input  read_uart, write_uart, write_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Byte command sequencer: pops W/R frames from the Rx FIFO, accesses
//            an NREGS x 8 register file and pushes one response byte per frame.
// Revision : 1.0
// ============================================================================
module uart_cmd_ctrl #(
    parameter int DBITS   = 8,
    parameter int NREGS   = 4,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_BITS = 20
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    uart_cmd_ctrl_if.master        fifo,
    output logic [NREGS*DBITS-1:0] reg_out,
    output logic                   busy,
    output logic [7:0]             err_count
);
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_GET_ADDR = 3'd1;
    localparam logic [2:0] c_ST_GET_DATA = 3'd2;
    localparam logic [2:0] c_ST_EXEC     = 3'd3;
    localparam logic [2:0] c_ST_SEND_RSP = 3'd4;

    localparam logic [DBITS-1:0] c_OP_W    = DBITS'('h57);
    localparam logic [DBITS-1:0] c_OP_R    = DBITS'('h52);
    localparam logic [DBITS-1:0] c_RSP_OK  = DBITS'('h4B);
    localparam logic [DBITS-1:0] c_RSP_UNK = DBITS'('h3F);
    localparam logic [DBITS-1:0] c_RSP_RNG = DBITS'('h21);
    localparam logic [DBITS-1:0] c_RSP_TO  = DBITS'('h54);

    localparam int               c_AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [DBITS:0]   c_NREGS   = (DBITS+1)'(NREGS);
    localparam logic [TO_BITS-1:0] c_TO_LAST = TO_BITS'(TIMEOUT - 1);

    logic [2:0]         state_q, state_d;
    logic               run_q;
    logic [DBITS-1:0]   op_q, addr_q, data_q, rsp_q;
    logic               rsp_err_q;
    logic [DBITS-1:0]   regs_q [NREGS];
    logic [7:0]         err_q;
    logic [TO_BITS-1:0] to_cnt_q;

    logic w_rx_state, w_pop, w_push, w_timeout, w_addr_ok, w_op_known;
    logic [c_AW-1:0] w_idx;

    // run_q keeps read_uart low while reset is asserted even if the FIFO has data
    assign w_rx_state = (state_q == c_ST_IDLE) || (state_q == c_ST_GET_ADDR) ||
                        (state_q == c_ST_GET_DATA);
    assign w_pop      = run_q && w_rx_state && !fifo.rx_empty;
    assign w_push     = (state_q == c_ST_SEND_RSP) && !fifo.tx_full;
    assign w_timeout  = ((state_q == c_ST_GET_ADDR) || (state_q == c_ST_GET_DATA)) &&
                        fifo.rx_empty && (to_cnt_q == c_TO_LAST);
    assign w_addr_ok  = {1'b0, addr_q} < c_NREGS;
    assign w_op_known = (fifo.read_data == c_OP_W) || (fifo.read_data == c_OP_R);
    assign w_idx      = addr_q[c_AW-1:0];

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= c_ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:
                if (w_pop) state_d = w_op_known ? c_ST_GET_ADDR : c_ST_SEND_RSP;
            c_ST_GET_ADDR:
                if (w_pop)          state_d = (op_q == c_OP_W) ? c_ST_GET_DATA : c_ST_EXEC;
                else if (w_timeout) state_d = c_ST_SEND_RSP;
            c_ST_GET_DATA:
                if (w_pop)          state_d = c_ST_EXEC;
                else if (w_timeout) state_d = c_ST_SEND_RSP;
            c_ST_EXEC:
                state_d = c_ST_SEND_RSP;
            c_ST_SEND_RSP:
                if (w_push) state_d = c_ST_IDLE;
            default:
                state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        fifo.read_uart  = w_pop;
        fifo.write_uart = w_push;
        busy            = (state_q != c_ST_IDLE);
    end

    assign fifo.write_data = rsp_q;
    assign err_count       = err_q;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rsp_q     <= '0;
            rsp_err_q <= 1'b0;
            err_q     <= '0;
            to_cnt_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (w_pop || !(state_q == c_ST_GET_ADDR || state_q == c_ST_GET_DATA))
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + TO_BITS'(1);

            if (w_pop) begin
                case (state_q)
                    c_ST_IDLE: begin
                        op_q <= fifo.read_data;
                        if (!w_op_known) begin
                            rsp_q     <= c_RSP_UNK;
                            rsp_err_q <= 1'b1;
                        end
                    end
                    c_ST_GET_ADDR: addr_q <= fifo.read_data;
                    default:       data_q <= fifo.read_data;
                endcase
            end else if (w_timeout) begin
                rsp_q     <= c_RSP_TO;
                rsp_err_q <= 1'b1;
            end

            // Only W and R opcodes can reach EXEC
            if (state_q == c_ST_EXEC) begin
                if (!w_addr_ok) begin
                    rsp_q     <= c_RSP_RNG;
                    rsp_err_q <= 1'b1;
                end else if (op_q == c_OP_W) begin
                    regs_q[w_idx] <= data_q;
                    rsp_q         <= c_RSP_OK;
                    rsp_err_q     <= 1'b0;
                end else begin
                    rsp_q     <= regs_q[w_idx];
                    rsp_err_q <= 1'b0;
                end
            end

            if (w_push && rsp_err_q && (err_q != 8'hFF))
                err_q <= err_q + 8'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regout
            assign reg_out[gi*DBITS +: DBITS] = regs_q[gi];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Self-checking bench for uart_cmd_ctrl (vector table + response scoreboard).
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_out;
    logic        busy;
    logic [7:0]  err_count;

    uart_cmd_ctrl_if #(.DBITS(8)) fifo ();

    uart_cmd_ctrl #(.DBITS(8), .NREGS(4), .TIMEOUT(TO), .TO_BITS(20)) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .fifo       (fifo),
        .reg_out    (reg_out),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] rsp;
        int         lat;
    } vec_t;

    logic [7:0] rxq [$];
    logic [7:0] expq [$];
    logic [7:0] mregs [4];
    int   n_cmp = 0, n_err = 0;
    int   cycle = 0, npops = 0, first_pop_cyc = -1, push_cyc = -1;
    int   exp_err = 0;
    bit   pop_pend = 0, txf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_regs();
        return {mregs[3], mregs[2], mregs[1], mregs[0]};
    endfunction

    // One cycle: model the FWFT Rx FIFO at the falling edge, sample the DUT 1 ns later
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        cycle++;
        if (pop_pend) begin
            if (rxq.size() > 0) rxq.delete(0);
            pop_pend = 0;
        end
        fifo.rx_empty  = (rxq.size() == 0);
        fifo.read_data = (rxq.size() == 0) ? 8'h00 : rxq[0];
        fifo.tx_full   = txf;
        #1;
        if (fifo.read_uart) begin
            pop_pend = 1;
            npops++;
            if (first_pop_cyc < 0) first_pop_cyc = cycle;
        end
        if (fifo.write_uart) begin
            push_cyc = cycle;
            if (expq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_push: got %h, required no push", fifo.write_data);
            end else begin
                e = expq.pop_front();
                check("rsp", {24'h0, fifo.write_data}, {24'h0, e});
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n, input logic [7:0] rsp, input int lat, input int budget);
        int p0;
        bit done;
        first_pop_cyc = -1;
        push_cyc      = -1;
        p0            = npops;
        rxq.push_back(b0);
        if (n > 1) rxq.push_back(b1);
        if (n > 2) rxq.push_back(b2);
        expq.push_back(rsp);
        if ((rsp == 8'h3F || rsp == 8'h21 || rsp == 8'h54) && exp_err < 255) exp_err++;
        if (b0 == 8'h57 && n == 3 && b1 < 8'd4) mregs[b1[1:0]] = b2;
        done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            done = (expq.size() == 0) && !busy;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_done: got pending=%0d busy=%0b, required pending=0 busy=0",
                     expq.size(), busy);
            expq.delete();
        end
        check("latency", push_cyc - first_pop_cyc, lat);
        check("pops", npops - p0, n);
        check("reg_out", reg_out, model_regs());
        check("err_count", {24'h0, err_count}, exp_err);
    endtask

    vec_t vt [13];

    initial begin
        int rel, wd_changes;
        logic [7:0] held;
        bit   seen;

        vt[0]  = '{8'h57, 8'h01, 8'hA5, 3, 8'h4B, 4};
        vt[1]  = '{8'h52, 8'h01, 8'h00, 2, 8'hA5, 3};
        vt[2]  = '{8'h41, 8'h00, 8'h00, 1, 8'h3F, 1};
        vt[3]  = '{8'h57, 8'h00, 8'h3C, 3, 8'h4B, 4};
        vt[4]  = '{8'h52, 8'h00, 8'h00, 2, 8'h3C, 3};
        vt[5]  = '{8'h57, 8'h07, 8'h33, 3, 8'h21, 4};
        vt[6]  = '{8'h52, 8'h05, 8'h00, 2, 8'h21, 3};
        vt[7]  = '{8'h57, 8'h03, 8'hFF, 3, 8'h4B, 4};
        vt[8]  = '{8'h52, 8'h03, 8'h00, 2, 8'hFF, 3};
        vt[9]  = '{8'h52, 8'h02, 8'h00, 2, 8'h00, 3};
        vt[10] = '{8'h57, 8'h02, 8'h52, 3, 8'h4B, 4};
        vt[11] = '{8'h52, 8'h02, 8'h00, 2, 8'h52, 3};
        vt[12] = '{8'h00, 8'h00, 8'h00, 1, 8'h3F, 1};
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;

        // Reset with data offered: no pop may be issued
        reset          = 1'b0;
        fifo.rx_empty  = 1'b0;
        fifo.read_data = 8'h57;
        fifo.tx_full   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_read_uart", {31'h0, fifo.read_uart}, 0);
        check("rst_write_uart", {31'h0, fifo.write_uart}, 0);
        check("rst_write_data", {24'h0, fifo.write_data}, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_err_count", {24'h0, err_count}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        fifo.rx_empty = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 13; i++)
            run_frame(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].n, vt[i].rsp, vt[i].lat, 60);
        check("table_final_regs", reg_out, 32'hFF52A53C);

        // Partial W frame then silence: timeout response, no register change
        run_frame(8'h57, 8'h02, 8'h00, 2, 8'h54, TO + 2, TO + 60);
        check("to_busy_low", {31'h0, busy}, 0);

        // Response held while Tx FIFO is full
        txf = 1;
        expq.push_back(mregs[0]);
        rxq.push_back(8'h52);
        rxq.push_back(8'h00);
        wd_changes = 0;
        held       = 8'h00;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (k == 5) held = fifo.write_data;
            if (k > 5 && fifo.write_data != held) wd_changes++;
        end
        check("full_no_push", expq.size(), 1);
        check("full_wd_stable", wd_changes, 0);
        check("full_wd_value", {24'h0, fifo.write_data}, {24'h0, mregs[0]});
        check("full_busy", {31'h0, busy}, 1);
        txf      = 0;
        push_cyc = -1;
        rel      = cycle + 1;
        seen     = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = (expq.size() == 0);
        end
        check("release_push_cycle", push_cyc, rel);
        tick();
        tick();

        // Reset in the middle of a W frame
        rxq.push_back(8'h57);
        rxq.push_back(8'h03);
        rel = npops;
        for (int k = 0; k < 20 && (npops - rel) < 2; k++) tick();
        check("midframe_pops", npops - rel, 2);
        reset = 1'b0;
        #1;
        check("mid_rst_reg_out", reg_out, 0);
        check("mid_rst_err", {24'h0, err_count}, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_write_data", {24'h0, fifo.write_data}, 0);
        check("mid_rst_read_uart", {31'h0, fifo.read_uart}, 0);
        rxq.delete();
        pop_pend = 0;
        exp_err  = 0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        run_frame(8'h52, 8'h03, 8'h00, 2, 8'h00, 3, 60);
        tick();
        tick();
        check("no_stray_push", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
